i2c_bus_arbiter: RTL
====================

Name: i2c_bus_arbiter

Overview:
- Shares the single codec I2C master between up to N requesters: the boot/volume register sequencer, a register read-back/debug port, and a runtime mixer/ALC tuner.
- Grants one requester at a time and latches its register address, write data and direction.
- Issues one exec pulse to the I2C master, waits for done or timeout, and returns read data and status to the granted requester.
- Enforces a minimum bus-idle gap between transactions.

Parameters:
- N, 3, number of requesters (2..4).
- PRIO0, 1, 1 = port 0 has strict priority over the others; 0 = pure round-robin across all ports.
- TIMEOUT_CYC, 16'd4000, clk cycles allowed in WAIT before the transaction is aborted as an error.
- GAP_CYC, 8'd4, idle clk cycles forced after every transaction.

Ports:
- clk  in  1  controller clock (same clock as the I2C master's drive clock).
- rst_n  in  1  reset.
- req_valid  in  N  per-port request; held high until that port's req_ready.
- req_rw  in  N  per-port direction: 1 = read, 0 = write.
- req_addr  in  8N  per-port register address; port k occupies bits [8k+7:8k].
- req_wdata  in  8N  per-port write data, same packing.
- req_ready  out  N  one-cycle accept pulse to the granted port.
- rsp_valid  out  N  one-cycle completion pulse to the granted port.
- rsp_rdata  out  8  read data, valid with rsp_valid.
- rsp_err  out  1  1 = NACK or timeout, valid with rsp_valid.
- i2c_exec  out  1  one-cycle start pulse to the I2C master.
- i2c_rh_wl  out  1  1 = read, 0 = write; held stable from exec until done.
- i2c_addr  out  8  register address; held stable from exec until done.
- i2c_wdata  out  8  write data; held stable from exec until done.
- i2c_done  in  1  one-cycle completion pulse from the I2C master.
- i2c_nack  in  1  sampled with i2c_done; 1 = slave did not acknowledge.
- i2c_rdata  in  8  read byte, sampled with i2c_done.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: every output = 0; state = IDLE; rr_ptr = 0.
- States:
  - IDLE: if any req_valid, select a winner, latch its rw/addr/wdata into the i2c_* registers, record grant index g, go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): i2c_exec = 1, req_ready[g] = 1, timeout counter cleared, go to WAIT.
  - WAIT: on i2c_done, capture rsp_rdata = i2c_rdata (writes return 0x00) and rsp_err = i2c_nack, go to RESP. If the counter reaches TIMEOUT_CYC-1 without done, set rsp_err = 1 and rsp_rdata = 0x00, go to RESP. If done and timeout coincide in the same cycle, done wins.
  - RESP (1 cycle): rsp_valid[g] = 1; rsp_rdata/rsp_err hold until the next RESP. Go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE. GAP_CYC = 0 means go to IDLE on the next cycle.
- Selection:
  - If PRIO0 = 1 and req_valid[0] = 1, port 0 wins.
  - Otherwise the first valid port found searching upward from rr_ptr, wrapping at N-1 -> 0.
  - After every grant, rr_ptr = g+1 (mod N). This includes port-0 priority grants.
- Latency: req_valid sampled in IDLE -> i2c_exec on the next cycle. i2c_done -> rsp_valid 1 cycle later. Minimum IDLE-to-IDLE transaction = 3 + master time + GAP_CYC cycles.
- i2c_done arriving outside WAIT (late done after a timeout) is ignored. It must not create a spurious rsp_valid.
- A requester dropping req_valid before req_ready is a protocol error. The request is already latched and the transaction still completes.
- req_ready and rsp_valid are exactly one-hot, or all zero, in every cycle.
- The timeout counter is 16 bits and saturates; it never wraps.
- Reset mid-transaction returns to IDLE immediately with all outputs 0; the in-flight I2C operation is abandoned.

Test Plan:
- Single write on port 1 (addr 0x2e, data 0x3c, master done after 50 cycles, nack = 0) -> i2c_exec 1 cycle after req_valid; i2c_addr = 0x2e and i2c_wdata = 0x3c stable to done; rsp_valid = 3'b010 with rsp_err = 0 one cycle after done.
- Read on port 2 (addr 0x08, i2c_rdata = 0x80) -> rsp_rdata = 0x80 with rsp_valid = 3'b100; i2c_rh_wl = 1 throughout.
- PRIO0 = 1, all three ports request continuously -> grant order 0,0,0... while port 0 holds; after port 0 drops: 1,2,1,2; GAP_CYC idle cycles seen between each exec.
- PRIO0 = 0, all ports request continuously -> grant order 0,1,2,0,1,2; no port starved.
- Master never returns done, TIMEOUT_CYC = 100 -> rsp_valid with rsp_err = 1 and rsp_rdata = 0x00, 101 cycles after exec. A later done pulse in GAP/IDLE produces no rsp_valid.
- NACK write (i2c_nack = 1 with done), then rst_n asserted during a following WAIT -> first rsp_err = 1; after reset all outputs 0, state IDLE, the next request is served normally.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Shares one codec I2C master between N requesters. Each transaction is
// granted (priority or round-robin), issued with a single exec pulse, and
// completed on done or timeout. A forced idle gap follows every transaction.
module i2c_bus_arbiter #(
  parameter int          N           = 3,
  parameter bit          PRIO0       = 1'b1,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000,
  parameter logic [7:0]  GAP_CYC     = 8'd4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_rw,
  input  logic [8*N-1:0] req_addr,
  input  logic [8*N-1:0] req_wdata,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [7:0]     rsp_rdata,
  output logic           rsp_err,
  output logic           i2c_exec,
  output logic           i2c_rh_wl,
  output logic [7:0]     i2c_addr,
  output logic [7:0]     i2c_wdata,
  input  logic           i2c_done,
  input  logic           i2c_nack,
  input  logic [7:0]     i2c_rdata,
  output logic           busy
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr, gnt, win;
  logic [15:0]   to_cnt;
  logic [7:0]    gap_cnt;
  logic          to_hit, gap_end;

  // Counter is saturating, so >= keeps the abort sticky even past the limit.
  assign to_hit  = (to_cnt >= TIMEOUT_CYC - 16'd1);
  assign gap_end = (GAP_CYC == 8'd0) || (gap_cnt >= GAP_CYC - 8'd1);

  // Winner: port 0 override when enabled, else first valid upward from rr_ptr.
  always_comb begin
    int  idx;
    logic found;
    win   = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!found && req_valid[idx]) begin
        win   = GW'(idx);
        found = 1'b1;
      end
    end
    if (PRIO0 && req_valid[0]) win = '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: done beats timeout when both land in the same WAIT cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (i2c_done || to_hit) state_nxt = RESP;
      RESP:    state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pulse outputs decoded from state; one-hot by construction via the shift.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    i2c_exec  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      ISSUE: begin
        req_ready = {{(N-1){1'b0}}, 1'b1} << gnt;
        i2c_exec  = 1'b1;
      end
      RESP:    rsp_valid = {{(N-1){1'b0}}, 1'b1} << gnt;
      default: ;
    endcase
  end

  // Grant latch, master command, counters and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      i2c_rh_wl <= 1'b0;
      i2c_addr  <= 8'h00;
      i2c_wdata <= 8'h00;
      to_cnt    <= 16'd0;
      gap_cnt   <= 8'd0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          gnt       <= win;
          rr_ptr    <= (win == GW'(N-1)) ? '0 : win + 1'b1;
          i2c_rh_wl <= req_rw[win];
          i2c_addr  <= req_addr[int'(win)*8 +: 8];
          i2c_wdata <= req_wdata[int'(win)*8 +: 8];
        end
        ISSUE: to_cnt <= 16'd0;
        WAIT: begin
          if (i2c_done) begin
            rsp_rdata <= i2c_rh_wl ? i2c_rdata : 8'h00;
            rsp_err   <= i2c_nack;
          end else if (to_hit) begin
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b1;
          end else if (to_cnt != 16'hffff) begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        RESP: gap_cnt <= 8'd0;
        GAP:  if (gap_cnt != 8'hff) gap_cnt <= gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
